// File: rtl/lm_sm_sequencer_if.sv
// Fetch-side bundle between the fetch stage (master) and the LM/SM sequencer (slave).
// The sequencer answers combinationally in the same cycle; stall and flush come from the pipeline.
interface lm_sm_sequencer_if;
  logic [15:0] fetch_IR;
  logic        stall;
  logic        flush;
  logic [15:0] new_IR_multi;
  logic        IR_load_mux;
  logic        pc_hold;
  logic        busy;
  logic [15:0] micro_op_count;

  modport master (
    output fetch_IR, stall, flush,
    input  new_IR_multi, IR_load_mux, pc_hold, busy, micro_op_count
  );

  modport slave (
    input  fetch_IR, stall, flush,
    output new_IR_multi, IR_load_mux, pc_hold, busy, micro_op_count
  );
endinterface

// File: rtl/lm_sm_sequencer.sv
// Expands LM/SM into one LW/SW micro-op per issued cycle (same-cycle combinational outputs);
// stall freezes the sequence, flush abandons it. Define LMSM_PERF_CNT_EN for the micro-op counter.
module lm_sm_sequencer #(
  parameter logic [15:0] NOP_IR = 16'hF000,
  parameter logic [3:0]  LM_OP  = 4'b0110,
  parameter logic [3:0]  SM_OP  = 4'b0111,
  parameter logic [3:0]  LW_OP  = 4'b0100,
  parameter logic [3:0]  SW_OP  = 4'b0101
) (
  input  logic             clk,
  input  logic             reset,
  lm_sm_sequencer_if.slave bus
);
  typedef enum logic {IDLE, SEQ} state_t;

  state_t      state, state_nxt;
  logic        is_lm_q, is_lm_nxt;
  logic [2:0]  base_q, base_nxt;
  logic [7:0]  orig_q, orig_nxt;
  logic [7:0]  rem_q, rem_nxt;

  logic        src_vld, src_lm;
  logic [2:0]  src_base;
  logic [7:0]  src_orig, src_rem;
  logic [2:0]  sel;
  logic [3:0]  left;
  logic [15:0] uop;
  logic        issue;
  logic        ld_mux, hold;
  logic [15:0] ir_out;
  logic        unused_fetch_bit8;

  assign unused_fetch_bit8 = bus.fetch_IR[8];

  // Lowest pending register; for LM the base register is held back until nothing else remains.
  function automatic logic [2:0] pick_reg(input logic lm, input logic [2:0] base,
                                          input logic [7:0] m);
    logic [7:0] cand;
    logic [2:0] idx;
    cand = m;
    if (lm) cand[base] = 1'b0;
    idx = base;
    for (int i = 7; i >= 0; i--) begin
      if (cand[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  function automatic logic [5:0] offset_of(input logic [7:0] m, input logic [2:0] idx);
    logic [7:0] below;
    below = m & ((8'd1 << idx) - 8'd1);
    return 6'($countones(below));
  endfunction

  always_comb begin
    if (state == SEQ) begin
      src_vld  = 1'b1;
      src_lm   = is_lm_q;
      src_base = base_q;
      src_orig = orig_q;
      src_rem  = rem_q;
    end else begin
      src_vld  = (bus.fetch_IR[15:12] == LM_OP) || (bus.fetch_IR[15:12] == SM_OP);
      src_lm   = (bus.fetch_IR[15:12] == LM_OP);
      src_base = bus.fetch_IR[11:9];
      src_orig = bus.fetch_IR[7:0];
      src_rem  = bus.fetch_IR[7:0];
    end
  end

  assign sel  = pick_reg(src_lm, src_base, src_rem);
  assign left = 4'($countones(src_rem));
  assign uop  = (left == 4'd0) ? NOP_IR
                               : {src_lm ? LW_OP : SW_OP, sel, src_base, offset_of(src_orig, sel)};

  always_comb begin
    state_nxt = state;
    is_lm_nxt = is_lm_q;
    base_nxt  = base_q;
    orig_nxt  = orig_q;
    rem_nxt   = rem_q;
    issue     = 1'b0;
    ld_mux    = 1'b0;
    hold      = 1'b0;
    ir_out    = '0;
    // Outputs stay quiet while reset is held so an aborted sequence emits nothing.
    if (reset && !bus.flush && src_vld) begin
      ld_mux = 1'b1;
      ir_out = uop;
      hold   = (left > 4'd1);
      if (!bus.stall) begin
        issue   = 1'b1;
        rem_nxt = src_rem & ~(8'd1 << sel);
        if (left > 4'd1) begin
          state_nxt = SEQ;
          is_lm_nxt = src_lm;
          base_nxt  = src_base;
          orig_nxt  = src_orig;
        end else begin
          state_nxt = IDLE;
        end
      end
    end else if (bus.flush) begin
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      is_lm_q <= 1'b0;
      base_q  <= '0;
      orig_q  <= '0;
      rem_q   <= '0;
    end else begin
      state   <= state_nxt;
      is_lm_q <= is_lm_nxt;
      base_q  <= base_nxt;
      orig_q  <= orig_nxt;
      rem_q   <= rem_nxt;
    end
  end

  assign bus.new_IR_multi = ir_out;
  assign bus.IR_load_mux  = ld_mux;
  assign bus.pc_hold      = hold;
  assign bus.busy         = (state == SEQ);

`ifdef LMSM_PERF_CNT_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     cnt_q <= '0;
    else if (issue) cnt_q <= cnt_q + 16'd1;
  end

  assign bus.micro_op_count = cnt_q;
`else
  logic unused_issue;
  assign unused_issue       = issue;
  assign bus.micro_op_count = 16'h0000;
`endif
endmodule

// File: tb/tb_lm_sm_sequencer.sv
// Bench for lm_sm_sequencer: the bench plays the fetch stage, a reference expander predicts each
// cycle's micro-op into a scoreboard queue and a negedge monitor compares whatever the DUT emits.
module tb_lm_sm_sequencer;
  localparam logic [3:0] LM = 4'b0110;
  localparam logic [3:0] SM = 4'b0111;

  typedef struct packed {
    logic [15:0] word;
    logic        hold;
    logic        busy;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  lm_sm_sequencer_if bus ();
  lm_sm_sequencer dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  exp_t        exp_q[$];
  logic [15:0] prog[$];
  int          pc = 0;
  int          pos = 0;
  int          model_cnt = 0;
  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 1'b0;

  function automatic logic [15:0] mk(input logic [3:0] op, input logic [2:0] base,
                                     input logic [7:0] mask);
    return {op, base, 1'b0, mask};
  endfunction

  function automatic bit is_lmsm(input logic [15:0] ir);
    return (ir[15:12] == LM) || (ir[15:12] == SM);
  endfunction

  function automatic int model_len(input logic [15:0] ir);
    return (ir[7:0] == 8'h00) ? 1 : $countones(ir[7:0]);
  endfunction

  // k-th micro-op of an LM/SM, straight from the expansion rules.
  function automatic logic [15:0] model_uop(input logic [15:0] ir, input int k);
    int         order[$];
    int         base;
    int         r;
    int         off;
    logic [7:0] m;
    bit         lm;
    m    = ir[7:0];
    base = int'(ir[11:9]);
    lm   = (ir[15:12] == LM);
    if (m == 8'h00) return 16'hF000;
    for (int i = 0; i < 8; i++) begin
      if (m[i] && !(lm && i == base)) order.push_back(i);
    end
    if (lm && m[base]) order.push_back(base);
    r   = order[k];
    off = 0;
    for (int i = 0; i < r; i++) begin
      if (m[i]) off++;
    end
    return {lm ? 4'b0100 : 4'b0101, 3'(r), ir[11:9], 6'(off)};
  endfunction

  function automatic logic [15:0] cur_ir();
    return (pc < prog.size()) ? prog[pc] : 16'h1234;
  endfunction

  function automatic logic [15:0] rand_ir();
    int         kind;
    logic [3:0] op;
    logic [7:0] mask;
    kind = $urandom_range(0, 9);
    if (kind < 4)      op = LM;
    else if (kind < 8) op = SM;
    else               op = 4'($urandom_range(8, 15));
    mask = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
    return {op, 3'($urandom_range(0, 7)), 1'($urandom), mask};
  endfunction

  // Called just after a rising edge: drive one cycle, predict it, then advance the fetch model.
  task automatic step(input bit st, input bit fl);
    logic [15:0] ir;
    exp_t        e;
    ir = cur_ir();
    bus.fetch_IR = ir;
    bus.stall    = st;
    bus.flush    = fl;
    if (!fl && is_lmsm(ir)) begin
      e.word = model_uop(ir, pos);
      e.hold = (pos != model_len(ir) - 1);
      e.busy = (pos != 0);
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    if (fl) begin
      pc++;
      pos = 0;
    end else if (!st) begin
      if (is_lmsm(ir)) begin
        model_cnt++;
        pos++;
        if (pos == model_len(ir)) begin
          pc++;
          pos = 0;
        end
      end else begin
        pc++;
      end
    end
  endtask

  task automatic run(input int stall_pct, input int flush_pct, input int budget);
    int n = 0;
    while (pc < prog.size() && n < budget) begin
      step($urandom_range(0, 99) < stall_pct, $urandom_range(0, 99) < flush_pct);
      n++;
    end
    checks++;
    if (pc < prog.size()) begin
      errors++;
      $display("FAIL run_budget: instruction %0d of %0d still pending after %0d cycles, required all consumed",
               pc, prog.size(), n);
    end
  endtask

  task automatic check_zero(input string name);
    checks++;
    if (bus.new_IR_multi !== 16'h0 || bus.IR_load_mux !== 1'b0 || bus.pc_hold !== 1'b0 ||
        bus.busy !== 1'b0 || bus.micro_op_count !== 16'h0) begin
      errors++;
      $display("FAIL %s: word=%h ld=%b hold=%b busy=%b cnt=%h, required all zero", name,
               bus.new_IR_multi, bus.IR_load_mux, bus.pc_hold, bus.busy, bus.micro_op_count);
    end
  endtask

  task automatic check_cnt(input string name);
    logic [15:0] want;
`ifdef LMSM_PERF_CNT_EN
    want = 16'(model_cnt);
`else
    want = 16'h0000;
`endif
    checks++;
    if (bus.micro_op_count !== want) begin
      errors++;
      $display("FAIL %s: micro_op_count=%h, required %h", name, bus.micro_op_count, want);
    end
  endtask

  // Reset pulse mid-cycle; flush keeps the just-released DUT from issuing before the model resumes.
  task automatic reset_mid();
    bus.stall = 1'b0;
    bus.flush = 1'b1;
    reset     = 1'b0;
    #1;
    check_zero("reset_mid_seq");
    @(negedge clk);
    #2;
    reset = 1'b1;
    @(posedge clk);
    #1;
    pc++;
    pos       = 0;
    model_cnt = 0;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (mon_en) begin
      checks++;
      if (bus.IR_load_mux === 1'b1) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_uop: got word=%h with IR_load_mux=1, required no micro-op",
                   bus.new_IR_multi);
        end else begin
          e = exp_q.pop_front();
          if (bus.new_IR_multi !== e.word || bus.pc_hold !== e.hold || bus.busy !== e.busy) begin
            errors++;
            $display("FAIL uop: got word=%h pc_hold=%b busy=%b, required word=%h pc_hold=%b busy=%b",
                     bus.new_IR_multi, bus.pc_hold, bus.busy, e.word, e.hold, e.busy);
          end
        end
      end else begin
        if (exp_q.size() != 0 || bus.pc_hold !== 1'b0) begin
          errors++;
          $display("FAIL no_uop: IR_load_mux=%b pc_hold=%b with %0d predicted, required ld=1 if predicted and pc_hold=0",
                   bus.IR_load_mux, bus.pc_hold, exp_q.size());
          if (exp_q.size() != 0) e = exp_q.pop_front();
        end
      end
    end
  end

  initial begin
    reset        = 1'b0;
    bus.fetch_IR = mk(LM, 3'd3, 8'h25);
    bus.stall    = 1'b0;
    bus.flush    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset_state");
    reset  = 1'b1;
    mon_en = 1'b1;

    prog.push_back(mk(LM, 3'd3, 8'h25));
    run(0, 0, 10);
    check_cnt("cnt_first_lm");

    prog.push_back(mk(SM, 3'd1, 8'h81));
    prog.push_back(mk(LM, 3'd2, 8'h06));
    prog.push_back(mk(LM, 3'd5, 8'h00));
    prog.push_back(mk(LM, 3'd0, 8'hFF));
    prog.push_back(mk(SM, 3'd5, 8'hFF));
    prog.push_back(mk(LM, 3'd4, 8'h10));
    prog.push_back(16'h1234);
    run(0, 0, 100);
    check_cnt("cnt_directed");

    prog.push_back(mk(LM, 3'd0, 8'h0E));
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    run(0, 0, 10);
    check_cnt("cnt_after_stall");

    prog.push_back(mk(LM, 3'd6, 8'hFF));
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    prog.push_back(mk(LM, 3'd2, 8'h0F));
    step(1'b0, 1'b1);
    prog.push_back(mk(SM, 3'd2, 8'h03));
    run(0, 0, 10);
    check_cnt("cnt_after_flush");

    prog.push_back(mk(LM, 3'd1, 8'hFF));
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    reset_mid();
    check_cnt("cnt_after_reset");

    for (int i = 0; i < 400; i++) prog.push_back(rand_ir());
    run(20, 5, 20000);
    check_cnt("cnt_final");

    step(1'b0, 1'b0);
    mon_en = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d predicted micro-ops never seen, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
